// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory, redirect and decode-handshake bundle of the
//            fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic        fault;

    modport slave (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_pc_plus4,
        output fault
    );

    modport master (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_pc_plus4,
        input  fault
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC register, instruction-memory address drive and a small
//            {pc, instr} FIFO feeding decode; redirects flush the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    fetch_unit_if.slave  io
);
    localparam int              c_PW    = $clog2(DEPTH);
    localparam int              c_CW    = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [31:0]     r_pc;
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_fault;
    logic [63:0]     r_mem [DEPTH];

    logic            w_pop;
    logic            w_push;
    logic            w_misaligned;

    assign w_pop        = io.out_valid && io.out_ready;
    assign w_push       = !io.redirect_valid && ((r_count < c_DEPTH) || w_pop);
    assign w_misaligned = (io.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_fault <= 1'b0;
        end else if (io.redirect_valid) begin
            // A same-cycle pop is simply absorbed: decode took the head, the rest is dropped.
            r_pc    <= {io.redirect_pc[31:2], 2'b00};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_fault <= r_fault | w_misaligned;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 32'd4;
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_pc, io.imem_instr};
        end
    end

    assign io.imem_addr    = r_pc;
    assign io.out_valid    = (r_count != '0);
    assign io.out_pc       = r_mem[r_rptr][63:32];
    assign io.out_instr    = r_mem[r_rptr][31:0];
    assign io.out_pc_plus4 = io.out_pc + 32'd4;
    assign io.fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit (default and
//            wrap-around reset PCs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    fetch_unit_if ifa ();
    fetch_unit_if ifb ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifa.slave)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifb.slave)
    );

    function automatic logic [31:0] imem_model(input logic [31:0] addr);
        if (addr == 32'h0)      return 32'h0250_0193;
        else if (addr == 32'h4) return 32'h0200_0513;
        else                    return addr ^ 32'hDEAD_0000;
    endfunction

    assign ifa.imem_instr = imem_model(ifa.imem_addr);
    assign ifb.imem_instr = imem_model(ifb.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifa.out_ready      = 1'b1;
        ifa.redirect_valid = 1'b0;
        ifa.redirect_pc    = 32'h0;
        ifb.out_ready      = 1'b1;
        ifb.redirect_valid = 1'b0;
        ifb.redirect_pc    = 32'h0;

        // Reset state
        step();
        chk("rst_valid_a", {31'b0, ifa.out_valid}, 32'd0);
        chk("rst_addr_a",  ifa.imem_addr, 32'h0);
        chk("rst_fault_a", {31'b0, ifa.fault}, 32'd0);
        chk("rst_valid_b", {31'b0, ifb.out_valid}, 32'd0);
        chk("rst_addr_b",  ifb.imem_addr, 32'hFFFF_FFF8);
        rst_n = 1'b1;

        // Streaming (A) and wrap-around (B)
        step();
        chk("s0_valid",  {31'b0, ifa.out_valid}, 32'd1);
        chk("s0_pc",     ifa.out_pc, 32'h0);
        chk("s0_instr",  ifa.out_instr, 32'h0250_0193);
        chk("s0_plus4",  ifa.out_pc_plus4, 32'h4);
        chk("w0_pc",     ifb.out_pc, 32'hFFFF_FFF8);
        step();
        chk("s1_pc",     ifa.out_pc, 32'h4);
        chk("s1_instr",  ifa.out_instr, 32'h0200_0513);
        chk("w1_pc",     ifb.out_pc, 32'hFFFF_FFFC);
        chk("w1_plus4",  ifb.out_pc_plus4, 32'h0);
        step();
        chk("s2_pc",     ifa.out_pc, 32'h8);
        chk("s2_instr",  ifa.out_instr, 32'hDEAD_0008);
        chk("w2_pc",     ifb.out_pc, 32'h0);
        step();
        chk("s3_pc",     ifa.out_pc, 32'hC);
        chk("s3_plus4",  ifa.out_pc_plus4, 32'h10);
        chk("w3_pc",     ifb.out_pc, 32'h4);

        // Backpressure
        ifa.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("bp_valid", {31'b0, ifa.out_valid}, 32'd1);
        chk("bp_pc",    ifa.out_pc, 32'h0);
        chk("bp_addr",  ifa.imem_addr, 32'h8);
        ifa.out_ready = 1'b1;
        step();
        chk("bp_rel1_pc", ifa.out_pc, 32'h4);
        chk("bp_rel1_v",  {31'b0, ifa.out_valid}, 32'd1);
        step();
        chk("bp_rel2_pc", ifa.out_pc, 32'h8);
        chk("bp_rel2_v",  {31'b0, ifa.out_valid}, 32'd1);

        // Flush with a pop in the redirect cycle
        ifa.out_ready = 1'b0;
        do_reset();
        step();
        step();
        chk("fl_pre_pc",   ifa.out_pc, 32'h0);
        chk("fl_pre_addr", ifa.imem_addr, 32'h8);
        ifa.out_ready      = 1'b1;
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 32'h40;
        step();
        ifa.redirect_valid = 1'b0;
        ifa.out_ready      = 1'b0;
        chk("fl_valid", {31'b0, ifa.out_valid}, 32'd0);
        chk("fl_addr",  ifa.imem_addr, 32'h40);
        step();
        chk("fl_tgt_v",     {31'b0, ifa.out_valid}, 32'd1);
        chk("fl_tgt_pc",    ifa.out_pc, 32'h40);
        chk("fl_tgt_instr", ifa.out_instr, 32'hDEAD_0040);
        chk("fl_fault",     {31'b0, ifa.fault}, 32'd0);

        // Misaligned redirect, sticky fault
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 32'h42;
        step();
        ifa.redirect_valid = 1'b0;
        chk("mis_addr",  ifa.imem_addr, 32'h40);
        chk("mis_fault", {31'b0, ifa.fault}, 32'd1);
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 32'h80;
        step();
        ifa.redirect_valid = 1'b0;
        chk("mis_al_addr",  ifa.imem_addr, 32'h80);
        chk("mis_al_fault", {31'b0, ifa.fault}, 32'd1);
        step();
        chk("mis_al_pc", ifa.out_pc, 32'h80);

        // Async reset between edges with two entries buffered
        step();
        chk("ar_pre_valid", {31'b0, ifa.out_valid}, 32'd1);
        chk("ar_pre_addr",  ifa.imem_addr, 32'h88);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, ifa.out_valid}, 32'd0);
        chk("ar_addr",  ifa.imem_addr, 32'h0);
        chk("ar_fault", {31'b0, ifa.fault}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_rst_pc", ifa.out_pc, 32'h0);
        chk("ar_rst_v",  {31'b0, ifa.out_valid}, 32'd1);
        ifa.out_ready = 1'b1;
        step();
        chk("ar_next_pc", ifa.out_pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
